// File: rtl/fp_pkg.sv
// Shared constants and helpers for IEEE-754-style operand handling.
// Class-bit indices, default field widths and an exponent all-ones test.
package fp_pkg;

  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 23;

  // Class vector bit order is {is_nan, is_inf, is_sub, is_zero}
  localparam int unsigned ClsZero = 0;
  localparam int unsigned ClsSub  = 1;
  localparam int unsigned ClsInf  = 2;
  localparam int unsigned ClsNan  = 3;

  typedef logic [3:0] cls_t;

  // exp_val is zero-extended; only the low exp_w bits are examined.
  function automatic logic exp_all_ones(input logic [31:0] exp_val, input int unsigned exp_w);
    logic [31:0] mask;
    mask = (32'd1 << exp_w) - 32'd1;
    return (exp_val & mask) == mask;
  endfunction

endpackage

// File: rtl/fp_operand_unpacker_if.sv
// Operand-pair input handshake and unpacked-result output handshake.
interface fp_operand_unpacker_if #(
  parameter int unsigned EXP_W = fp_pkg::DEF_EXP_W,
  parameter int unsigned MAN_W = fp_pkg::DEF_MAN_W
) ();
  import fp_pkg::*;

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     operand1;
  logic [W-1:0]     operand2;

  logic             out_valid;
  logic             out_ready;
  logic             SL;
  logic             SS;
  logic [EXP_W-1:0] EL;
  logic [EXP_W-1:0] ES;
  logic [MAN_W:0]   ML;
  logic [MAN_W:0]   MS;
  logic [EXP_W-1:0] exp_diff;
  logic             swapped;
  cls_t             cls1;
  cls_t             cls2;

  modport master (
    output in_valid, operand1, operand2, out_ready,
    input  in_ready, out_valid, SL, SS, EL, ES, ML, MS, exp_diff, swapped, cls1, cls2
  );

  modport slave (
    input  in_valid, operand1, operand2, out_ready,
    output in_ready, out_valid, SL, SS, EL, ES, ML, MS, exp_diff, swapped, cls1, cls2
  );

endinterface

// File: rtl/fp_field_decode.sv
// Splits one raw word into sign, effective exponent, significand and class.
module fp_field_decode
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] word_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_eff_o,
  output logic [MAN_W:0]       sig_o,
  output cls_t                 cls_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;
  logic             exp_zero;
  logic             exp_ones;
  logic             frac_zero;

  assign {sign_o, exp_f, frac_f} = word_i;

  assign exp_zero  = (exp_f == '0);
  assign exp_ones  = exp_all_ones(32'(exp_f), EXP_W);
  assign frac_zero = (frac_f == '0);

  // Subnormals share the scale of exponent 1, so align them there.
  assign exp_eff_o = exp_zero ? EXP_W'(1) : exp_f;
  assign sig_o     = {!exp_zero, frac_f};

  always_comb begin
    cls_o          = '0;
    cls_o[ClsZero] = exp_zero && frac_zero;
    cls_o[ClsSub]  = exp_zero && !frac_zero;
    cls_o[ClsInf]  = exp_ones && frac_zero;
    cls_o[ClsNan]  = exp_ones && !frac_zero;
  end

endmodule

// File: rtl/fp_operand_unpacker.sv
// Two-stage operand unpacker: stage 1 decodes both words, stage 2 orders
// them by magnitude and computes the saturated exponent difference.
module fp_operand_unpacker
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W    = DEF_EXP_W,
  parameter int unsigned MAN_W    = DEF_MAN_W,
  parameter int unsigned DIFF_SAT = MAN_W + 3
) (
  input logic                  clk,
  input logic                  rst_n,
  fp_operand_unpacker_if.slave bus
);

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_ready;
  logic s1_advance;
  logic in_fire;

  assign s2_ready    = !s2_valid_q || bus.out_ready;
  assign s1_advance  = s1_valid_q && s2_ready;
  assign bus.in_ready = !s1_valid_q || s1_advance;
  assign in_fire     = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_advance) s1_valid_d = 1'b0;
    if (in_fire)    s1_valid_d = 1'b1;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s2_ready) s2_valid_d = s1_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage 1: decode
  logic             dec1_sign, dec2_sign;
  logic [EXP_W-1:0] dec1_exp,  dec2_exp;
  logic [MAN_W:0]   dec1_sig,  dec2_sig;
  cls_t             dec1_cls,  dec2_cls;

  fp_field_decode #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_dec1 (
    .word_i   (bus.operand1),
    .sign_o   (dec1_sign),
    .exp_eff_o(dec1_exp),
    .sig_o    (dec1_sig),
    .cls_o    (dec1_cls)
  );

  fp_field_decode #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_dec2 (
    .word_i   (bus.operand2),
    .sign_o   (dec2_sign),
    .exp_eff_o(dec2_exp),
    .sig_o    (dec2_sig),
    .cls_o    (dec2_cls)
  );

  logic             s1_sign1_q, s1_sign2_q;
  logic [EXP_W-1:0] s1_exp1_q,  s1_exp2_q;
  logic [MAN_W:0]   s1_sig1_q,  s1_sig2_q;
  cls_t             s1_cls1_q,  s1_cls2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign1_q <= 1'b0;
      s1_sign2_q <= 1'b0;
      s1_exp1_q  <= '0;
      s1_exp2_q  <= '0;
      s1_sig1_q  <= '0;
      s1_sig2_q  <= '0;
      s1_cls1_q  <= '0;
      s1_cls2_q  <= '0;
    end else if (in_fire) begin
      s1_sign1_q <= dec1_sign;
      s1_sign2_q <= dec2_sign;
      s1_exp1_q  <= dec1_exp;
      s1_exp2_q  <= dec2_exp;
      s1_sig1_q  <= dec1_sig;
      s1_sig2_q  <= dec2_sig;
      s1_cls1_q  <= dec1_cls;
      s1_cls2_q  <= dec2_cls;
    end
  end

  // Stage 2: compare, swap, exponent difference
  logic [EXP_W+MAN_W:0] key1, key2;
  logic                 swap_d;
  logic                 sl_d, ss_d;
  logic [EXP_W-1:0]     el_d, es_d;
  logic [MAN_W:0]       ml_d, ms_d;
  logic [EXP_W-1:0]     diff_raw;
  logic [EXP_W-1:0]     exp_diff_d;

  assign key1   = {s1_exp1_q, s1_sig1_q};
  assign key2   = {s1_exp2_q, s1_sig2_q};
  // Ties keep operand1 as the larger one.
  assign swap_d = (key2 > key1);

  always_comb begin
    sl_d = s1_sign1_q;
    ss_d = s1_sign2_q;
    el_d = s1_exp1_q;
    es_d = s1_exp2_q;
    ml_d = s1_sig1_q;
    ms_d = s1_sig2_q;
    if (swap_d) begin
      sl_d = s1_sign2_q;
      ss_d = s1_sign1_q;
      el_d = s1_exp2_q;
      es_d = s1_exp1_q;
      ml_d = s1_sig2_q;
      ms_d = s1_sig1_q;
    end
  end

  assign diff_raw = el_d - es_d;

  always_comb begin
    exp_diff_d = diff_raw;
    if (32'(diff_raw) > DIFF_SAT) exp_diff_d = EXP_W'(DIFF_SAT);
  end

  logic             s2_sl_q, s2_ss_q;
  logic [EXP_W-1:0] s2_el_q, s2_es_q;
  logic [MAN_W:0]   s2_ml_q, s2_ms_q;
  logic [EXP_W-1:0] s2_exp_diff_q;
  logic             s2_swapped_q;
  cls_t             s2_cls1_q, s2_cls2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sl_q       <= 1'b0;
      s2_ss_q       <= 1'b0;
      s2_el_q       <= '0;
      s2_es_q       <= '0;
      s2_ml_q       <= '0;
      s2_ms_q       <= '0;
      s2_exp_diff_q <= '0;
      s2_swapped_q  <= 1'b0;
      s2_cls1_q     <= '0;
      s2_cls2_q     <= '0;
    end else if (s1_advance) begin
      s2_sl_q       <= sl_d;
      s2_ss_q       <= ss_d;
      s2_el_q       <= el_d;
      s2_es_q       <= es_d;
      s2_ml_q       <= ml_d;
      s2_ms_q       <= ms_d;
      s2_exp_diff_q <= exp_diff_d;
      s2_swapped_q  <= swap_d;
      s2_cls1_q     <= s1_cls1_q;
      s2_cls2_q     <= s1_cls2_q;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.SL        = s2_sl_q;
  assign bus.SS        = s2_ss_q;
  assign bus.EL        = s2_el_q;
  assign bus.ES        = s2_es_q;
  assign bus.ML        = s2_ml_q;
  assign bus.MS        = s2_ms_q;
  assign bus.exp_diff  = s2_exp_diff_q;
  assign bus.swapped   = s2_swapped_q;
  assign bus.cls1      = s2_cls1_q;
  assign bus.cls2      = s2_cls2_q;

endmodule

// File: tb/tb_fp_operand_unpacker.sv
// Directed self-checking bench for fp_operand_unpacker (single precision).
module tb_fp_operand_unpacker;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  typedef logic [82:0] out_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fp_operand_unpacker_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_operand_unpacker #(
    .EXP_W   (EXP_W),
    .MAN_W   (MAN_W),
    .DIFF_SAT(MAN_W + 3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  out_vec_t obs;
  assign obs = {bus.SL, bus.SS, bus.EL, bus.ES, bus.ML, bus.MS,
                bus.exp_diff, bus.swapped, bus.cls1, bus.cls2};

  function automatic out_vec_t mk(input logic sl, input logic ss, input logic [7:0] el,
                                  input logic [7:0] es, input logic [23:0] ml,
                                  input logic [23:0] ms, input logic [7:0] d, input logic sw,
                                  input logic [3:0] c1, input logic [3:0] c2);
    return {sl, ss, el, es, ml, ms, d, sw, c1, c2};
  endfunction

  // Presents one pair into an empty pipeline with out_ready high and reports
  // out_valid one cycle after acceptance and two cycles after acceptance.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          output logic v_early, output logic v_late);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.operand1 = a;
    bus.operand2 = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.operand1 = 'x;
    bus.operand2 = 'x;
    v_early = bus.out_valid;
    @(posedge clk); #1;
    v_late = bus.out_valid;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.operand1  = 'x;
    bus.operand2  = 'x;
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
    end
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h required 0", obs);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || obs !== '0) begin
      failures++;
      $display("FAIL idle_x_operands: out_valid=%b data=%h required 0 and 0", bus.out_valid, obs);
    end
  endtask

  task automatic test_normal();
    logic ve, vl;
    out_vec_t exp_v;
    send_one(32'h3F80_0000, 32'h4000_0000, ve, vl);
    exp_v = mk(1'b0, 1'b0, 8'd128, 8'd127, 24'h80_0000, 24'h80_0000, 8'd1, 1'b1, 4'b0000, 4'b0000);
    checks++;
    if (ve !== 1'b0 || vl !== 1'b1) begin
      failures++;
      $display("FAIL normal_latency: out_valid got %b,%b required 0,1", ve, vl);
    end
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL normal_fields: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_subnormal();
    logic ve, vl;
    out_vec_t exp_v;
    send_one(32'h0000_0001, 32'h0000_0000, ve, vl);
    exp_v = mk(1'b0, 1'b0, 8'd1, 8'd1, 24'h00_0001, 24'h00_0000, 8'd0, 1'b0, 4'b0010, 4'b0001);
    checks++;
    if (ve !== 1'b0 || vl !== 1'b1) begin
      failures++;
      $display("FAIL subnormal_latency: out_valid got %b,%b required 0,1", ve, vl);
    end
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL subnormal_fields: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_special();
    logic ve, vl;
    out_vec_t exp_v;
    send_one(32'h7F80_0000, 32'h7FC0_0000, ve, vl);
    exp_v = mk(1'b0, 1'b0, 8'hFF, 8'hFF, 24'hC0_0000, 24'h80_0000, 8'd0, 1'b1, 4'b0100, 4'b1000);
    checks++;
    if (ve !== 1'b0 || vl !== 1'b1) begin
      failures++;
      $display("FAIL special_latency: out_valid got %b,%b required 0,1", ve, vl);
    end
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL special_fields: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_saturation();
    logic ve, vl;
    out_vec_t exp_v;
    send_one(32'h3F80_0000, 32'h0B80_0000, ve, vl);
    exp_v = mk(1'b0, 1'b0, 8'd127, 8'd23, 24'h80_0000, 24'h80_0000, 8'd26, 1'b0, 4'b0000, 4'b0000);
    checks++;
    if (ve !== 1'b0 || vl !== 1'b1) begin
      failures++;
      $display("FAIL saturation_latency: out_valid got %b,%b required 0,1", ve, vl);
    end
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL saturation_fields: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_sign();
    logic ve, vl;
    out_vec_t exp_v;
    send_one(32'hC040_0000, 32'h3F00_0000, ve, vl);
    exp_v = mk(1'b1, 1'b0, 8'd128, 8'd126, 24'hC0_0000, 24'h80_0000, 8'd2, 1'b0, 4'b0000, 4'b0000);
    checks++;
    if (ve !== 1'b0 || vl !== 1'b1) begin
      failures++;
      $display("FAIL sign_latency: out_valid got %b,%b required 0,1", ve, vl);
    end
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL sign_fields: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_q [8];
    out_vec_t    exp_q [8];
    out_vec_t    held;
    logic        stalled, in_fire;
    int          sent, got, bubbles, leaked;
    for (int i = 0; i < 8; i++) begin
      a_q[i] = {1'b0, 8'(120 + i), 23'(i)};
      if (i < 7) begin
        exp_q[i] = mk(1'b0, 1'b0, 8'd127, 8'(120 + i), 24'h80_0000, 24'h80_0000 | 24'(i),
                      8'(7 - i), 1'b1, 4'b0000, 4'b0000);
      end else begin
        exp_q[i] = mk(1'b0, 1'b0, 8'd127, 8'd127, 24'h80_0007, 24'h80_0000,
                      8'd0, 1'b0, 4'b0000, 4'b0000);
      end
    end
    sent = 0; got = 0; bubbles = 0; stalled = 1'b0; held = '0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.operand1  = a_q[0];
    bus.operand2  = 32'h3F80_0000;
    bus.out_ready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (bus.out_valid !== 1'b1 || obs !== held) begin
          failures++;
          $display("FAIL b2b_stall_hold: valid=%b data=%h required 1 and %h", bus.out_valid, obs,
                   held);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (obs !== exp_q[got]) begin
          failures++;
          $display("FAIL b2b_pair%0d: got %h required %h", got, obs, exp_q[got]);
        end
        got++;
      end else if (bus.out_ready === 1'b1 && got > 0) begin
        bubbles++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = obs;
      in_fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (in_fire) begin
        sent++;
        if (sent < 8) begin
          bus.operand1 = a_q[sent];
        end else begin
          bus.in_valid = 1'b0;
          bus.operand1 = 'x;
          bus.operand2 = 'x;
        end
      end
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    if (got != 8) begin
      failures++;
      $display("FAIL b2b_count: emitted %0d required 8", got);
    end
    checks++;
    if (bubbles != 0) begin
      failures++;
      $display("FAIL b2b_throughput: bubbles %0d required 0", bubbles);
    end
    bus.out_ready = 1'b1;
    leaked = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) leaked++;
    end
    checks++;
    if (leaked != 0) begin
      failures++;
      $display("FAIL b2b_extra_output: extra valid cycles %0d required 0", leaked);
    end
  endtask

  task automatic test_reset_mid();
    logic ve, vl;
    int leaked;
    out_vec_t exp_v;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.operand1 = 32'h3F80_0000;
    bus.operand2 = 32'h4000_0000;
    @(posedge clk); #1;
    bus.operand1 = 32'h4040_0000;
    bus.operand2 = 32'h3F80_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.operand1 = 'x;
    bus.operand2 = 'x;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_loaded: out_valid=%b in_ready=%b required 1 and 0", bus.out_valid,
               bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || obs !== '0) begin
      failures++;
      $display("FAIL midreset_clear: out_valid=%b data=%h required 0 and 0", bus.out_valid, obs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_in_ready: got %b required 1", bus.in_ready);
    end
    leaked = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) leaked++;
    end
    checks++;
    if (leaked != 0) begin
      failures++;
      $display("FAIL midreset_dropped: valid cycles %0d required 0", leaked);
    end
    send_one(32'h4000_0000, 32'h3F80_0000, ve, vl);
    exp_v = mk(1'b0, 1'b0, 8'd128, 8'd127, 24'h80_0000, 24'h80_0000, 8'd1, 1'b0, 4'b0000, 4'b0000);
    checks++;
    if (ve !== 1'b0 || vl !== 1'b1) begin
      failures++;
      $display("FAIL midreset_latency: out_valid got %b,%b required 0,1", ve, vl);
    end
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL midreset_fields: got %h required %h", obs, exp_v);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operand1  = '0;
    bus.operand2  = '0;
    test_reset();
    test_normal();
    test_subnormal();
    test_special();
    test_saturation();
    test_sign();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_operand_unpacker.md
FP_OPERAND_UNPACKER -- requirements
Module: fp_operand_unpacker

Interface
REQ-001 The block SHALL provide parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL provide parameter MAN_W, default 23, meaning stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL provide parameter DIFF_SAT, default MAN_W+3, meaning the saturation value of the exponent difference.
REQ-004 The block SHALL have clk  input  1  the single clock, all state updated on its rising edge.
REQ-005 The block SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have in_valid  input  1  the operand pair is valid.
REQ-007 The block SHALL have in_ready  output  1  the block accepts the pair this cycle.
REQ-008 The block SHALL have operand1 and operand2  input  W each  raw IEEE-754-style words.
REQ-009 The block SHALL have out_valid  output  1  and out_ready  input  1  as the result handshake.
REQ-010 The block SHALL have SL/SS  output  1 each  the signs of the larger-magnitude and smaller-magnitude operands.
REQ-011 The block SHALL have EL/ES  output  EXP_W each  the effective exponents of the larger and smaller operands.
REQ-012 The block SHALL have ML/MS  output  MAN_W+1 each  the significands with the hidden bit.
REQ-013 The block SHALL have exp_diff  output  EXP_W  the value EL-ES, saturated at DIFF_SAT.
REQ-014 The block SHALL have swapped  output  1  set when operand2 is the larger operand.
REQ-015 The block SHALL have cls1/cls2  output  4 each  the classes of operand1/operand2, bit order {is_nan, is_inf, is_sub, is_zero}.

Function
REQ-016 Unpack: the hidden bit SHALL be 1 iff exp!=0, and an effective exponent of 0 SHALL be replaced by 1 (subnormal alignment).
REQ-017 Classification: zero = exp==0 and frac==0; sub = exp==0 and frac!=0; inf = exp all-ones and frac==0; nan = exp all-ones and frac!=0.
REQ-018 Pipeline stage 1 SHALL register the unpacked fields and classes; stage 2 SHALL register the magnitude compare, swap and exp_diff; latency SHALL be 2 cycles with no stalls.
REQ-019 Magnitude compare SHALL use {exp_eff, significand} unsigned; on equality no swap occurs (swapped=0, operand1 is larger).
REQ-020 A transfer SHALL occur on in_valid&&in_ready and, at the output, on out_valid&&out_ready.
REQ-021 Each stage SHALL load when it is empty or its downstream consumer takes its contents in the same cycle; in_ready = !s1_valid || s1_advance (combinational from out_ready, no skid buffer).
REQ-022 With out_ready held high the pipeline SHALL sustain one pair per cycle with no bubbles.
REQ-023 While out_valid=1 and out_ready=0 all outputs SHALL hold stable.
REQ-024 Simultaneous accept and emit in the same cycle SHALL both complete, and stage occupancy SHALL be unchanged.
REQ-025 Data registers SHALL NOT change when their stage does not load; X on operand inputs while in_valid=0 SHALL NOT propagate to the valid flags.
REQ-026 The cls outputs SHALL track the original operand order, unaffected by the swap.

Reset
REQ-027 rst_n low SHALL immediately clear s1_valid, s2_valid/out_valid and all data outputs to 0, and in_ready SHALL read 1 after reset is released.
REQ-028 Reset asserted mid-operation SHALL drop in-flight pairs without emitting them, and the first pair after release SHALL emerge after exactly 2 cycles.

Structure
REQ-029 A shared package fp_pkg SHALL hold the class-bit index constants, the default EXP_W/MAN_W, and the all-ones exponent helper.
REQ-030 A sub-module fp_field_decode (one word -> sign, exp_eff, significand, class) SHALL be instantiated twice in stage 1.

Verification
REQ-031 The bench SHALL apply operand1=0x3F800000, operand2=0x40000000 -> SL=0, EL=128, ES=127, exp_diff=1, swapped=1, ML=MS=0x800000.
REQ-032 The bench SHALL apply 0x00000001 vs 0x00000000 -> cls1=0010, cls2=0001, EL=ES=1, ML=0x000001, MS=0, swapped=0.
REQ-033 The bench SHALL apply 0x7F800000 vs 0x7FC00000 -> cls1=0100, cls2=1000, swapped=1 (NaN fraction larger).
REQ-034 The bench SHALL apply 0x3F800000 vs 0x0B800000 -> exp_diff=26 (saturated from 104), swapped=0.
REQ-035 The bench SHALL stream 8 back-to-back pairs with out_ready toggling randomly -> every pair is emitted in order exactly once, outputs are stable while stalled, and throughput is 1/cycle when out_ready=1.
REQ-036 The bench SHALL pulse rst_n low with 2 pairs in flight -> out_valid=0 immediately, neither pair is emitted, and the next accepted pair appears 2 cycles later.
